// File: rtl/seq_tx_image_single_if.sv
// Groups the SRAM read bus and the pixel valid/ready handshake of the single-pixel
// TX read-back sequencer. The sequencer is the master; SRAMs and the TX builder are the slave.
interface seq_tx_image_single_if;
    logic [31:0] red_read_data;
    logic [31:0] green_read_data;
    logic [31:0] blue_read_data;
    logic        sram_r_rd_en;
    logic        sram_g_rd_en;
    logic        sram_b_rd_en;
    logic [13:0] sram_r_addr_rd;
    logic [13:0] sram_g_addr_rd;
    logic [13:0] sram_b_addr_rd;
    logic [7:0]  tx_red_pixel;
    logic [7:0]  tx_green_pixel;
    logic [7:0]  tx_blue_pixel;
    logic        tx_pixel_valid;
    logic        tx_pixel_ready;

    modport master (
        input  red_read_data, green_read_data, blue_read_data, tx_pixel_ready,
        output sram_r_rd_en, sram_g_rd_en, sram_b_rd_en,
        output sram_r_addr_rd, sram_g_addr_rd, sram_b_addr_rd,
        output tx_red_pixel, tx_green_pixel, tx_blue_pixel, tx_pixel_valid
    );

    modport slave (
        output red_read_data, green_read_data, blue_read_data, tx_pixel_ready,
        input  sram_r_rd_en, sram_g_rd_en, sram_b_rd_en,
        input  sram_r_addr_rd, sram_g_addr_rd, sram_b_addr_rd,
        input  tx_red_pixel, tx_green_pixel, tx_blue_pixel, tx_pixel_valid
    );
endinterface

// File: rtl/seq_tx_image_single.sv
// Reads packed R/G/B words back from the channel SRAMs and streams them one pixel at a time.
// Optional macro SEQ_TX_ABORT_EN adds the tx_abort input that cancels a read-back in progress.
module seq_tx_image_single (
    input  logic                          clk,
    input  logic                          rst_n,
    input  logic [7:0]                    img_width,
    input  logic [7:0]                    img_height,
    input  logic                          start,
`ifdef SEQ_TX_ABORT_EN
    input  logic                          tx_abort,
`endif
    seq_tx_image_single_if.master         bus,
    output logic                          tx_seq_single_busy,
    output logic                          tx_seq_single_dn
);

    localparam logic [2:0] IDLE       = 3'd0;
    localparam logic [2:0] RD_REQ     = 3'd1;
    localparam logic [2:0] RD_CAPTURE = 3'd2;
    localparam logic [2:0] SEND       = 3'd3;
    localparam logic [2:0] CMPLTD     = 3'd4;

    logic [2:0]  state_q,     state_d;
    logic [13:0] word_cnt_q,  word_cnt_d;
    logic [13:0] num_words_q, num_words_d;
    logic [1:0]  pix_cnt_q,   pix_cnt_d;
    logic [31:0] red_buf_q,   red_buf_d;
    logic [31:0] green_buf_q, green_buf_d;
    logic [31:0] blue_buf_q,  blue_buf_d;

    logic [15:0] img_area;
    logic [13:0] start_words;
    logic        abort_req;

    // Trailing pixels that do not fill a whole word are dropped by the floor division.
    assign img_area    = {8'd0, img_width} * {8'd0, img_height};
    assign start_words = img_area[15:2];

`ifdef SEQ_TX_ABORT_EN
    assign abort_req = tx_abort;
`else
    assign abort_req = 1'b0;
`endif

    always_comb begin
        state_d     = state_q;
        word_cnt_d  = word_cnt_q;
        num_words_d = num_words_q;
        pix_cnt_d   = pix_cnt_q;
        red_buf_d   = red_buf_q;
        green_buf_d = green_buf_q;
        blue_buf_d  = blue_buf_q;

        case (state_q)
            IDLE: begin
                if (start) begin
                    num_words_d = start_words;
                    word_cnt_d  = 14'd0;
                    state_d     = (start_words == 14'd0) ? CMPLTD : RD_REQ;
                end
            end
            RD_REQ: begin
                state_d = RD_CAPTURE;
            end
            RD_CAPTURE: begin
                red_buf_d   = bus.red_read_data;
                green_buf_d = bus.green_read_data;
                blue_buf_d  = bus.blue_read_data;
                pix_cnt_d   = 2'd0;
                state_d     = SEND;
            end
            SEND: begin
                if (bus.tx_pixel_ready) begin
                    red_buf_d   = {red_buf_q[23:0],   8'h00};
                    green_buf_d = {green_buf_q[23:0], 8'h00};
                    blue_buf_d  = {blue_buf_q[23:0],  8'h00};
                    pix_cnt_d   = pix_cnt_q + 2'd1;
                    if (pix_cnt_q == 2'd3) begin
                        word_cnt_d = word_cnt_q + 14'd1;
                        state_d    = (word_cnt_d < num_words_q) ? RD_REQ : CMPLTD;
                    end
                end
            end
            CMPLTD: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase

        // A handshake in the abort cycle has already been counted above; only the state is overridden.
        if (abort_req && (state_q != IDLE)) begin
            state_d = IDLE;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= IDLE;
            word_cnt_q  <= 14'd0;
            num_words_q <= 14'd0;
            pix_cnt_q   <= 2'd0;
            red_buf_q   <= 32'd0;
            green_buf_q <= 32'd0;
            blue_buf_q  <= 32'd0;
        end else begin
            state_q     <= state_d;
            word_cnt_q  <= word_cnt_d;
            num_words_q <= num_words_d;
            pix_cnt_q   <= pix_cnt_d;
            red_buf_q   <= red_buf_d;
            green_buf_q <= green_buf_d;
            blue_buf_q  <= blue_buf_d;
        end
    end

    // Outputs decode state and registers only, so tx_pixel_ready never reaches an output.
    always_comb begin
        bus.sram_r_rd_en   = 1'b0;
        bus.sram_g_rd_en   = 1'b0;
        bus.sram_b_rd_en   = 1'b0;
        bus.sram_r_addr_rd = 14'd0;
        bus.sram_g_addr_rd = 14'd0;
        bus.sram_b_addr_rd = 14'd0;
        bus.tx_red_pixel   = 8'd0;
        bus.tx_green_pixel = 8'd0;
        bus.tx_blue_pixel  = 8'd0;
        bus.tx_pixel_valid = 1'b0;
        tx_seq_single_busy = 1'b0;
        tx_seq_single_dn   = 1'b0;

        case (state_q)
            RD_REQ: begin
                bus.sram_r_rd_en   = 1'b1;
                bus.sram_g_rd_en   = 1'b1;
                bus.sram_b_rd_en   = 1'b1;
                bus.sram_r_addr_rd = word_cnt_q;
                bus.sram_g_addr_rd = word_cnt_q;
                bus.sram_b_addr_rd = word_cnt_q;
                tx_seq_single_busy = 1'b1;
            end
            RD_CAPTURE: begin
                tx_seq_single_busy = 1'b1;
            end
            SEND: begin
                bus.tx_red_pixel   = red_buf_q[31:24];
                bus.tx_green_pixel = green_buf_q[31:24];
                bus.tx_blue_pixel  = blue_buf_q[31:24];
                bus.tx_pixel_valid = 1'b1;
                tx_seq_single_busy = 1'b1;
            end
            CMPLTD: begin
                tx_seq_single_dn = 1'b1;
            end
            default: begin
            end
        endcase
    end

endmodule

// File: tb/tb_seq_tx_image_single.sv
// Bench for seq_tx_image_single: directed corner sequences, a vector table and randomized
// image read-backs checked against a pixel-stream model built from the SRAM contents.
module tb_seq_tx_image_single;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic [7:0] img_width = 8'd0;
    logic [7:0] img_height = 8'd0;
    logic       start = 1'b0;
`ifdef SEQ_TX_ABORT_EN
    logic       tx_abort = 1'b0;
    logic       abort_with_start = 1'b0;
`endif
    logic       busy;
    logic       dn;

    seq_tx_image_single_if bus();

    seq_tx_image_single dut (
        .clk                (clk),
        .rst_n              (rst_n),
        .img_width          (img_width),
        .img_height         (img_height),
        .start              (start),
`ifdef SEQ_TX_ABORT_EN
        .tx_abort           (tx_abort),
`endif
        .bus                (bus),
        .tx_seq_single_busy (busy),
        .tx_seq_single_dn   (dn)
    );

    always #5 clk = ~clk;

    // SRAM model: registered read, data valid the cycle after rd_en
    logic [31:0] mem_r [16384];
    logic [31:0] mem_g [16384];
    logic [31:0] mem_b [16384];

    always @(posedge clk) begin
        if (bus.sram_r_rd_en) begin
            bus.red_read_data   <= mem_r[bus.sram_r_addr_rd];
            bus.green_read_data <= mem_g[bus.sram_g_addr_rd];
            bus.blue_read_data  <= mem_b[bus.sram_b_addr_rd];
        end
    end

    int checks = 0;
    int errors = 0;
    int cyc = 0;
    int rmode = 1;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h expected=%0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // ready: 0 never, 1 always, 2 toggle, 3 random 3/4
    initial begin
        bus.tx_pixel_ready = 1'b1;
        forever begin
            @(posedge clk);
            #1;
            case (rmode)
                0:       bus.tx_pixel_ready = 1'b0;
                1:       bus.tx_pixel_ready = 1'b1;
                2:       bus.tx_pixel_ready = ~bus.tx_pixel_ready;
                default: bus.tx_pixel_ready = ($urandom_range(0, 3) != 0);
            endcase
        end
    end

    // Reference model: expected pixel stream and address sequence
    typedef struct packed { logic [7:0] r; logic [7:0] g; logic [7:0] b; } pix_t;
    pix_t exp_pix_q[$];
    int   exp_addr_q[$];

    task automatic build_model(input int w, input int h);
        int nw;
        nw = (w * h) / 4;
        exp_pix_q.delete();
        exp_addr_q.delete();
        for (int wd = 0; wd < nw; wd++) begin
            exp_addr_q.push_back(wd);
            for (int p = 0; p < 4; p++) begin
                pix_t px;
                px.r = 8'((mem_r[wd] >> (8 * (3 - p))) & 32'hFF);
                px.g = 8'((mem_g[wd] >> (8 * (3 - p))) & 32'hFF);
                px.b = 8'((mem_b[wd] >> (8 * (3 - p))) & 32'hFF);
                exp_pix_q.push_back(px);
            end
        end
    endtask

    int rd_cnt, hs_cnt, valid_cnt, busy_cnt, dn_cnt, dn_cyc, first_valid_cyc, t_start;
    logic        prev_valid = 1'b0;
    logic        prev_ready = 1'b0;
    logic [23:0] prev_pix = 24'd0;

    always @(negedge clk) begin
        logic [23:0] pix;
        pix = {bus.tx_red_pixel, bus.tx_green_pixel, bus.tx_blue_pixel};
        chk("rden_equal", {bus.sram_g_rd_en, bus.sram_b_rd_en}, {2{bus.sram_r_rd_en}});
        chk("addr_equal", {bus.sram_g_addr_rd, bus.sram_b_addr_rd}, {2{bus.sram_r_addr_rd}});
        if (!bus.sram_r_rd_en) chk("addr_zero_no_rd", bus.sram_r_addr_rd, 0);
        if (bus.sram_r_rd_en) begin
            rd_cnt++;
            if (exp_addr_q.size() == 0) chk("rd_unexpected", bus.sram_r_addr_rd, 64'hDEAD);
            else chk("rd_addr", bus.sram_r_addr_rd, exp_addr_q.pop_front());
        end
        if (prev_valid && !prev_ready) begin
            chk("hold_valid", bus.tx_pixel_valid, 1);
            chk("hold_pixel", pix, prev_pix);
        end
        if (bus.tx_pixel_valid) begin
            valid_cnt++;
            if (first_valid_cyc < 0) first_valid_cyc = cyc;
            chk("busy_with_valid", busy, 1);
            if (bus.tx_pixel_ready) begin
                hs_cnt++;
                if (exp_pix_q.size() == 0) chk("hs_unexpected", pix, 64'hDEAD);
                else chk("pixel", pix, exp_pix_q.pop_front());
            end
        end
        if (busy) busy_cnt++;
        if (dn) begin
            dn_cnt++;
            dn_cyc = cyc;
            chk("busy_at_dn", busy, 0);
        end
        prev_valid = bus.tx_pixel_valid;
        prev_ready = bus.tx_pixel_ready;
        prev_pix   = pix;
    end

    task automatic reset_stats();
        rd_cnt = 0; hs_cnt = 0; valid_cnt = 0; busy_cnt = 0;
        dn_cnt = 0; dn_cyc = -1; first_valid_cyc = -1;
    endtask

    task automatic check_all_zero(input string tag);
        chk({tag, "_rden"}, {bus.sram_r_rd_en, bus.sram_g_rd_en, bus.sram_b_rd_en}, 0);
        chk({tag, "_addr"}, {bus.sram_r_addr_rd, bus.sram_g_addr_rd, bus.sram_b_addr_rd}, 0);
        chk({tag, "_pix"}, {bus.tx_red_pixel, bus.tx_green_pixel, bus.tx_blue_pixel}, 0);
        chk({tag, "_ctl"}, {bus.tx_pixel_valid, busy, dn}, 0);
    endtask

    task automatic begin_txn(input int w, input int h, input int rm);
        @(posedge clk);
        #1;
        rmode = rm;
        if (rm == 1) bus.tx_pixel_ready = 1'b1;
        build_model(w, h);
        reset_stats();
        img_width  = 8'(w);
        img_height = 8'(h);
        start      = 1'b1;
`ifdef SEQ_TX_ABORT_EN
        tx_abort   = abort_with_start;
`endif
        t_start    = cyc;
        @(posedge clk);
        #1;
        start      = 1'b0;
`ifdef SEQ_TX_ABORT_EN
        tx_abort   = 1'b0;
`endif
        img_width  = 8'($urandom);
        img_height = 8'($urandom);
    endtask

    task automatic end_txn(input string tag, input int exp_words, input bit timing);
        int budget;
        int n;
        budget = 200 + exp_words * 60;
        n = 0;
        while (dn_cnt == 0 && n < budget) begin
            @(negedge clk);
            n++;
        end
        chk({tag, "_dn_seen"}, (dn_cnt != 0), 1);
        repeat (4) @(negedge clk);
        chk({tag, "_dn_count"}, dn_cnt, 1);
        chk({tag, "_hs_count"}, hs_cnt, 4 * exp_words);
        chk({tag, "_rd_count"}, rd_cnt, exp_words);
        chk({tag, "_pix_left"}, exp_pix_q.size(), 0);
        if (timing) chk({tag, "_dn_latency"}, dn_cyc - t_start, 6 * exp_words + 1);
        if (exp_words > 0) begin
            if (timing) chk({tag, "_first_valid"}, first_valid_cyc - t_start, 3);
        end else begin
            chk({tag, "_no_valid"}, valid_cnt, 0);
            chk({tag, "_no_busy"}, busy_cnt, 0);
        end
    endtask

    typedef struct { int w; int h; int rm; int exp_words; string name; } vec_t;
    vec_t tbl[9];

    initial begin
        automatic pix_t p2x2 [4] = '{24'h115599, 24'h2266AA, 24'h3377BB, 24'h4488CC};

        tbl[0] = '{2,   2,  1, 1,  "v2x2"};
        tbl[1] = '{4,   4,  2, 4,  "v4x4_toggle"};
        tbl[2] = '{3,   1,  1, 0,  "v3x1"};
        tbl[3] = '{4,   2,  1, 2,  "v4x2"};
        tbl[4] = '{7,   5,  2, 8,  "v7x5_toggle"};
        tbl[5] = '{13,  1,  3, 3,  "v13x1_rand"};
        tbl[6] = '{0,   9,  1, 0,  "v0x9"};
        tbl[7] = '{100, 3,  1, 75, "v100x3"};
        tbl[8] = '{16,  16, 3, 64, "v16x16_rand"};

        for (int i = 0; i < 16384; i++) begin
            mem_r[i] = $urandom; mem_g[i] = $urandom; mem_b[i] = $urandom;
        end
        bus.red_read_data = 32'd0; bus.green_read_data = 32'd0; bus.blue_read_data = 32'd0;
        reset_stats();

        repeat (3) @(posedge clk);
        #1;
        check_all_zero("reset");
        rst_n = 1'b1;

        // 2x2 image with exact pixel timing
        mem_r[0] = 32'h11223344; mem_g[0] = 32'h55667788; mem_b[0] = 32'h99AABBCC;
        begin_txn(2, 2, 1);
        repeat (3) @(negedge clk);
        for (int i = 0; i < 4; i++) begin
            chk("t2x2_valid", bus.tx_pixel_valid, 1);
            chk("t2x2_pixel", {bus.tx_red_pixel, bus.tx_green_pixel, bus.tx_blue_pixel}, p2x2[i]);
            @(negedge clk);
        end
        chk("t2x2_dn", dn, 1);
        chk("t2x2_busy_low", busy, 0);
        end_txn("t2x2", 1, 1);

        // start pulsed again during SEND must be ignored
        begin_txn(2, 2, 1);
        repeat (4) @(negedge clk);
        @(posedge clk);
        #1;
        start = 1'b1; img_width = 8'd8; img_height = 8'd8;
        @(posedge clk);
        #1;
        start = 1'b0;
        end_txn("restart_ign", 1, 1);

        // reset during second word's SEND, then restart from address 0
        begin_txn(4, 2, 1);
        repeat (9) @(negedge clk);
        @(posedge clk);
        #1;
        chk("midrst_pre_valid", bus.tx_pixel_valid, 1);
        rst_n = 1'b0;
        #1;
        check_all_zero("midrst");
        exp_pix_q.delete();
        exp_addr_q.delete();
        repeat (2) @(posedge clk);
        #1;
        rst_n = 1'b1;
        repeat (6) @(negedge clk);
        chk("midrst_no_dn", dn_cnt, 0);
        chk("midrst_rd_count", rd_cnt, 2);
        begin_txn(2, 2, 1);
        end_txn("after_rst", 1, 1);

`ifdef SEQ_TX_ABORT_EN
        // abort during the second word of a 4x4 read-back
        begin_txn(4, 4, 1);
        repeat (9) @(negedge clk);
        @(posedge clk);
        #1;
        tx_abort = 1'b1;
        @(posedge clk);
        #1;
        tx_abort = 1'b0;
        chk("abort_idle", {bus.tx_pixel_valid, busy, bus.sram_r_rd_en}, 0);
        chk("abort_hs_count", hs_cnt, 6);
        exp_pix_q.delete();
        exp_addr_q.delete();
        repeat (8) @(negedge clk);
        chk("abort_no_dn", dn_cnt, 0);
        chk("abort_rd_count", rd_cnt, 2);
        abort_with_start = 1'b1;
        begin_txn(2, 2, 1);
        abort_with_start = 1'b0;
        end_txn("abort_restart", 1, 1);
`endif

        for (int i = 0; i < 9; i++) begin
            begin_txn(tbl[i].w, tbl[i].h, tbl[i].rm);
            end_txn(tbl[i].name, tbl[i].exp_words, tbl[i].rm == 1);
        end

        for (int i = 0; i < 25; i++) begin
            int w, h, rm;
            w  = $urandom_range(0, 16);
            h  = $urandom_range(0, 16);
            rm = $urandom_range(1, 3);
            for (int a = 0; a < 64; a++) begin
                mem_r[a] = $urandom; mem_g[a] = $urandom; mem_b[a] = $urandom;
            end
            begin_txn(w, h, rm);
            end_txn("rand", (w * h) / 4, rm == 1);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #900000;
        $display("FAIL watchdog expired actual=running required=finished");
        $fatal(1, "watchdog");
    end

endmodule

// File: doc/seq_tx_image_single.md
# seq_tx_image_single

Read-back sequencer that sits directly downstream of the single-pixel RX write sequencer. It reads the packed 32-bit R/G/B words that the RX sequencer wrote into the three channel SRAMs, unpacks them into one pixel (R, G, B bytes) at a time, and hands each pixel to the UART TX message builder over a valid/ready handshake. It is started by the command handler on an image-read request.

## Interface

Parameters: none.

Ports:
- clk  in  1  system clock
- rst_n  in  1  reset; asynchronous assert, active-low
- img_width  in  8  image width from RGF; sampled on accepted start
- img_height  in  8  image height from RGF; sampled on accepted start
- start  in  1  one-cycle pulse requesting full image read-back
- red_read_data / green_read_data / blue_read_data  in  32 each  SRAM read data, valid the cycle after rd_en
- sram_r_rd_en / sram_g_rd_en / sram_b_rd_en  out  1 each  SRAM read enables (always asserted together)
- sram_r_addr_rd / sram_g_addr_rd / sram_b_addr_rd  out  14 each  word address (identical on all three)
- tx_red_pixel / tx_green_pixel / tx_blue_pixel  out  8 each  current pixel bytes
- tx_pixel_valid  out  1  pixel bytes valid
- tx_pixel_ready  in  1  TX builder accepts pixel
- tx_seq_single_busy  out  1  high while a read-back is in progress
- tx_seq_single_dn  out  1  one-cycle pulse when read-back completes
- tx_abort  in  1  present only with SEQ_TX_ABORT_EN (see Configuration)

## Operation

- Word count: num_words = (img_width*img_height) >> 2, 16-bit product, floor division; latched at start. Maximum value 16256 fits in 14 bits. Trailing 1–3 pixels when the product is not a multiple of 4 are not sent.
- Word packing matches the RX writer: pixel 0 = bits [31:24], pixel 1 = [23:16], pixel 2 = [15:8], pixel 3 = [7:0]. Pixels are sent in that order; words are sent in address order 0 … num_words-1.
- State machine:
  - IDLE: outputs are 0. If start=1 and num_words=0, go to CMPLTD. If start=1 and num_words>0, clear word_cnt and go to RD_REQ. Otherwise stay in IDLE.
  - RD_REQ: all three rd_en=1; addr=word_cnt; go to RD_CAPTURE.
  - RD_CAPTURE: register the three read_data words into shift buffers; clear pix_cnt; go to SEND.
  - SEND: tx_pixel_valid=1; tx_*_pixel = buffer[31:24].
    - On valid&&ready: shift each buffer left 8 and increment pix_cnt.
    - If that handshake was the 4th pixel: increment word_cnt, then go to RD_REQ if more words remain, else to CMPLTD.
  - CMPLTD: tx_seq_single_dn=1 for one cycle; go to IDLE.
- tx_seq_single_busy=1 in RD_REQ, RD_CAPTURE and SEND; 0 in IDLE and CMPLTD.
- start outside IDLE is ignored. img_width/img_height changes after start are ignored.
- Pixel data and valid must stay stable while valid=1 and ready=0. valid never drops without a handshake, except on reset or abort.
- Address outputs are 0 whenever rd_en=0.

## Timing

- Reset: state=IDLE. Every output is 0 (rd_en, addr, tx pixels, valid, busy, dn). Buffers and counters are cleared.
- start is sampled in cycle T; rd_en is high in T+1; capture happens in T+2; first tx_pixel_valid is in T+3.
- With ready held high: 6 cycles per word (RD_REQ, RD_CAPTURE, 4× SEND). The dn pulse occurs 1 cycle after the last handshake.
- num_words=0: dn is in T+1; busy is never asserted.
- Reset asserted mid-operation: immediate return to reset values. No dn. No further SRAM reads.
- tx_pixel_valid and tx_*_pixel are driven from state and registers only. There is no combinational path from tx_pixel_ready to any output.

## Configuration

- SEQ_TX_ABORT_EN defined:
  - Adds input tx_abort.
  - tx_abort=1 in any non-IDLE state forces the next state to IDLE. No dn pulse is issued and no further rd_en.
  - A pixel handshaking in the same cycle as abort counts as sent.
  - tx_abort in IDLE is ignored, including when coincident with start (abort wins only outside IDLE).
- SEQ_TX_ABORT_EN undefined:
  - No tx_abort port.
  - A read-back ends only via CMPLTD or reset.

## Test plan

- 2×2 image, SRAM word 0 = R 0x11223344, G 0x55667788, B 0x99AABBCC, ready=1:
  - one read at addr 0;
  - pixels (11,55,99), (22,66,AA), (33,77,BB), (44,88,CC) on consecutive cycles T+3…T+6;
  - dn at T+7, busy low at T+7.
- 4×4 image, 4 words of distinct data, ready toggling 1/0 every cycle:
  - addresses 0,1,2,3 in order;
  - 16 pixels in order;
  - data held stable across ready=0 cycles;
  - exactly one dn.
- 3×1 image (num_words=0):
  - dn one cycle after start;
  - no rd_en;
  - valid never high.
- start pulsed again during SEND of a 2×2 read-back: ignored; output identical to the first scenario.
- 4×2 image, rst_n asserted during the second word's SEND:
  - all outputs 0 immediately, no dn;
  - a subsequent start restarts from address 0.
- With SEQ_TX_ABORT_EN, 4×4 image, tx_abort during the second word:
  - IDLE next cycle, no dn, no further rd_en;
  - a new start reads from address 0.
